n101_icb1to2_bus: RTL
=====================

Name: n101_icb1to2_bus

Overview:
- Splits one upstream ICB initiator port into two downstream ICB target ports by address region. This is the fan-out counterpart of the 2:1 ICB merge bus.
- Sits between a fabric master and two slaves, for example the main bus and a private peripheral region.
- Tracks outstanding transactions so responses return in command order.
- No payload buffering: cmd and rsp paths are zero-latency combinational; the only state is routing and ordering.

Parameters:
- AW, 32, address width.
- DW, 32, data width; DW/8 mask bits.
- O1_BASE_ADDR, 32'h1000_0000, base address of the o1 region.
- O1_REGION_LSB, 28, LSB of the address compare; bits [AW-1:O1_REGION_LSB] are compared.
- OUTS_NUM, 2, maximum outstanding commands; range 1..2^OUTS_CNT_W-1.
- OUTS_CNT_W, 2, width of the outstanding counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_icb_cmd_valid  in  1  upstream cmd valid.
- i_icb_cmd_ready  out  1  upstream cmd ready.
- i_icb_cmd_addr  in  AW  cmd address.
- i_icb_cmd_read  in  1  1=read, 0=write.
- i_icb_cmd_wdata  in  DW  write data.
- i_icb_cmd_wmask  in  DW/8  byte write mask.
- i_icb_cmd_size  in  2  transfer size.
- i_icb_rsp_valid  out  1  upstream rsp valid.
- i_icb_rsp_ready  in  1  upstream rsp ready.
- i_icb_rsp_err  out  1  response error.
- i_icb_rsp_rdata  out  DW  read data.
- o0_/o1_icb_cmd_valid  out  1  downstream cmd valid.
- o0_/o1_icb_cmd_ready  in  1  downstream cmd ready.
- o0_/o1_icb_cmd_addr, _read, _wdata, _wmask, _size  out  AW/1/DW/DW/8/2  payload broadcast to both ports.
- o0_/o1_icb_rsp_valid  in  1  downstream rsp valid.
- o0_/o1_icb_rsp_ready  out  1  downstream rsp ready.
- o0_/o1_icb_rsp_err  in  1  downstream rsp error.
- o0_/o1_icb_rsp_rdata  in  DW  downstream read data.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Target select: sel = (i_icb_cmd_addr[AW-1:O1_REGION_LSB] == O1_BASE_ADDR[AW-1:O1_REGION_LSB]). sel=1 routes to o1, otherwise o0.
- State registers:
  - outs_cnt[OUTS_CNT_W-1:0], reset 0.
  - cur_sel, reset 0; holds the target of the in-flight commands.
- Command blocking: cmd_blk = (outs_cnt==OUTS_NUM) | (outs_cnt!=0 & sel!=cur_sel).
  - Full counter stalls.
  - A target switch stalls until all prior responses have drained; this guarantees in-order responses.
- Command path:
  - ok_valid = i_icb_cmd_valid & ~cmd_blk & (sel==k).
  - i_icb_cmd_ready = ~cmd_blk & (sel ? o1_icb_cmd_ready : o0_icb_cmd_ready).
  - cmd_hsk = i_icb_cmd_valid & i_icb_cmd_ready.
  - A valid cmd must not be withdrawn by the master; the block passes valid/payload through unchanged.
- Response path:
  - i_icb_rsp_valid = (outs_cnt!=0) & (cur_sel ? o1_icb_rsp_valid : o0_icb_rsp_valid).
  - err/rdata muxed by cur_sel.
  - ok_rsp_ready = (outs_cnt!=0) & (cur_sel==k) & i_icb_rsp_ready.
  - rsp_hsk = i_icb_rsp_valid & i_icb_rsp_ready.
- Counter update:
  - cmd_hsk only: +1.
  - rsp_hsk only: -1.
  - Both in the same cycle: hold.
  - cur_sel <= sel on cmd_hsk.
- Latency: 0 cycles on cmd and rsp paths. Same-cycle rsp for a command in the same cycle is not supported; targets respond at least 1 cycle after cmd_hsk.
- Boundaries:
  - Switch after drain: cmd_blk uses the registered outs_cnt. When the last rsp pops with a pending switch, the new cmd is accepted the following cycle (one bubble).
  - Spurious response: downstream rsp_valid while outs_cnt==0, or from the non-selected port, is not acknowledged (ready=0) and not forwarded.
  - Counter limits: outs_cnt never exceeds OUTS_NUM and never underflows.
- Reset:
  - While rst=1: i_icb_cmd_ready, o0/o1_icb_cmd_valid, i_icb_rsp_valid and o0/o1_icb_rsp_ready are forced 0.
  - Reset mid-operation clears outs_cnt and cur_sel; in-flight responses are abandoned, so downstream targets must be reset in the same domain.

Test Plan (O1_BASE_ADDR=32'h1000_0000, O1_REGION_LSB=28, OUTS_NUM=2):
- Routing: read to 32'h1000_0040 -> o1_cmd_valid=1, o0_cmd_valid=0, outs_cnt 0->1. o1 returns rdata 32'hDEAD_BEEF -> i_rsp_rdata=32'hDEAD_BEEF, i_rsp_err=0, outs_cnt 1->0.
- Full stall: three back-to-back cmds to 32'h0000_0100 with rsp held off -> two accepted, third sees i_cmd_ready=0, outs_cnt=2. One rsp_hsk -> third accepted next cycle.
- Target switch: cmd to o0 outstanding, next cmd to 32'h1000_0000 -> stalled (o1_cmd_valid=0) until the o0 rsp handshake, then accepted the following cycle with o1_cmd_valid=1.
- Simultaneous events: outs_cnt=1 on o0, cmd_hsk to o0 and rsp_hsk in the same cycle -> outs_cnt stays 1, cur_sel=0.
- Spurious/error response: o1_rsp_valid=1 while outs_cnt=0 -> o1_rsp_ready=0, i_rsp_valid=0. Then an o0 rsp with err=1 for an outstanding write -> i_rsp_err=1.
- Reset mid-operation: rst pulsed with outs_cnt=2 -> all valid/ready outputs 0 during reset; next cycle outs_cnt=0 and i_cmd_ready follows o0_cmd_ready for an address in 32'h0xxx_xxxx.

Source files
------------

// File: rtl/n101_icb1to2_bus.sv
// 1:2 ICB fan-out: routes upstream commands to o0/o1 by address region and
// returns responses in command order by only ever having one target in flight.
module n101_icb1to2_bus #(
    parameter int              AW            = 32,
    parameter int              DW            = 32,
    parameter logic [AW-1:0]   O1_BASE_ADDR  = 32'h1000_0000,
    parameter int              O1_REGION_LSB = 28,
    parameter int              OUTS_NUM      = 2,
    parameter int              OUTS_CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_icb_cmd_valid,
    output logic              i_icb_cmd_ready,
    input  logic [AW-1:0]     i_icb_cmd_addr,
    input  logic              i_icb_cmd_read,
    input  logic [DW-1:0]     i_icb_cmd_wdata,
    input  logic [DW/8-1:0]   i_icb_cmd_wmask,
    input  logic [1:0]        i_icb_cmd_size,
    output logic              i_icb_rsp_valid,
    input  logic              i_icb_rsp_ready,
    output logic              i_icb_rsp_err,
    output logic [DW-1:0]     i_icb_rsp_rdata,

    output logic              o0_icb_cmd_valid,
    input  logic              o0_icb_cmd_ready,
    output logic [AW-1:0]     o0_icb_cmd_addr,
    output logic              o0_icb_cmd_read,
    output logic [DW-1:0]     o0_icb_cmd_wdata,
    output logic [DW/8-1:0]   o0_icb_cmd_wmask,
    output logic [1:0]        o0_icb_cmd_size,
    input  logic              o0_icb_rsp_valid,
    output logic              o0_icb_rsp_ready,
    input  logic              o0_icb_rsp_err,
    input  logic [DW-1:0]     o0_icb_rsp_rdata,

    output logic              o1_icb_cmd_valid,
    input  logic              o1_icb_cmd_ready,
    output logic [AW-1:0]     o1_icb_cmd_addr,
    output logic              o1_icb_cmd_read,
    output logic [DW-1:0]     o1_icb_cmd_wdata,
    output logic [DW/8-1:0]   o1_icb_cmd_wmask,
    output logic [1:0]        o1_icb_cmd_size,
    input  logic              o1_icb_rsp_valid,
    output logic              o1_icb_rsp_ready,
    input  logic              o1_icb_rsp_err,
    input  logic [DW-1:0]     o1_icb_rsp_rdata
);

    localparam logic [OUTS_CNT_W-1:0] OUTS_MAX = OUTS_CNT_W'(OUTS_NUM);
    localparam logic [OUTS_CNT_W-1:0] CNT_ONE  = OUTS_CNT_W'(1);

    logic [OUTS_CNT_W-1:0] outs_cnt_q, outs_cnt_d;
    logic                  cur_sel_q, cur_sel_d;
    logic                  sel, cnt_nz, cmd_blk, cmd_hsk, rsp_hsk;

    assign sel    = (i_icb_cmd_addr[AW-1:O1_REGION_LSB] == O1_BASE_ADDR[AW-1:O1_REGION_LSB]);
    assign cnt_nz = (outs_cnt_q != '0);
    // A target switch waits for a full drain so responses cannot reorder.
    assign cmd_blk = (outs_cnt_q == OUTS_MAX) | (cnt_nz & (sel != cur_sel_q));

    assign i_icb_cmd_ready  = ~rst & ~cmd_blk & (sel ? o1_icb_cmd_ready : o0_icb_cmd_ready);
    assign o0_icb_cmd_valid = ~rst & i_icb_cmd_valid & ~cmd_blk & ~sel;
    assign o1_icb_cmd_valid = ~rst & i_icb_cmd_valid & ~cmd_blk &  sel;

    assign o0_icb_cmd_addr  = i_icb_cmd_addr;
    assign o0_icb_cmd_read  = i_icb_cmd_read;
    assign o0_icb_cmd_wdata = i_icb_cmd_wdata;
    assign o0_icb_cmd_wmask = i_icb_cmd_wmask;
    assign o0_icb_cmd_size  = i_icb_cmd_size;
    assign o1_icb_cmd_addr  = i_icb_cmd_addr;
    assign o1_icb_cmd_read  = i_icb_cmd_read;
    assign o1_icb_cmd_wdata = i_icb_cmd_wdata;
    assign o1_icb_cmd_wmask = i_icb_cmd_wmask;
    assign o1_icb_cmd_size  = i_icb_cmd_size;

    // Responses are only taken from the port that owns the in-flight commands.
    assign i_icb_rsp_valid  = ~rst & cnt_nz & (cur_sel_q ? o1_icb_rsp_valid : o0_icb_rsp_valid);
    assign i_icb_rsp_err    = cur_sel_q ? o1_icb_rsp_err   : o0_icb_rsp_err;
    assign i_icb_rsp_rdata  = cur_sel_q ? o1_icb_rsp_rdata : o0_icb_rsp_rdata;
    assign o0_icb_rsp_ready = ~rst & cnt_nz & ~cur_sel_q & i_icb_rsp_ready;
    assign o1_icb_rsp_ready = ~rst & cnt_nz &  cur_sel_q & i_icb_rsp_ready;

    assign cmd_hsk = i_icb_cmd_valid & i_icb_cmd_ready;
    assign rsp_hsk = i_icb_rsp_valid & i_icb_rsp_ready;

    always_comb begin
        outs_cnt_d = outs_cnt_q;
        cur_sel_d  = cur_sel_q;
        if (cmd_hsk & ~rsp_hsk) begin
            outs_cnt_d = outs_cnt_q + CNT_ONE;
        end else if (rsp_hsk & ~cmd_hsk) begin
            outs_cnt_d = outs_cnt_q - CNT_ONE;
        end
        if (cmd_hsk) begin
            cur_sel_d = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outs_cnt_q <= '0;
            cur_sel_q  <= 1'b0;
        end else begin
            outs_cnt_q <= outs_cnt_d;
            cur_sel_q  <= cur_sel_d;
        end
    end

endmodule
